// File: rtl/reflet_bus_pkg.sv
// Shared types and constants for the reflet bus controller and its address decoder.
package reflet_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } bus_state_t;

  localparam int WAIT_W   = 4;
  localparam int NREG_MAX = 8;
  localparam int IDX_W    = $clog2(NREG_MAX);

endpackage

// File: rtl/reflet_bus_decode.sv
// Combinational region decoder: a region matches when (addr & mask) == base,
// and the lowest-index match wins when regions overlap.
module reflet_bus_decode
  import reflet_bus_pkg::*;
#(
  parameter int                     WORDSIZE    = 16,
  parameter int                     NREG        = 4,
  parameter logic [NREG*WORDSIZE-1:0] REGION_BASE = '0,
  parameter logic [NREG*WORDSIZE-1:0] REGION_MASK = '0
) (
  input  logic [WORDSIZE-1:0] addr,
  output logic                hit,
  output logic [NREG-1:0]     onehot,
  output logic [IDX_W-1:0]    region
);

  // Scan from the top so the lowest matching index is written last.
  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    region = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((addr & REGION_MASK[i*WORDSIZE +: WORDSIZE]) == REGION_BASE[i*WORDSIZE +: WORDSIZE]) begin
        hit       = 1'b1;
        onehot    = '0;
        onehot[i] = 1'b1;
        region    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reflet_bus_ctrl.sv
// Single-master bus controller: boot reset stretcher, region decode with
// per-region wait states, and a sticky record of the first unmapped access.
module reflet_bus_ctrl
  import reflet_bus_pkg::*;
#(
  parameter int                       WORDSIZE    = 16,
  parameter int                       NREG        = 4,
  parameter logic [NREG*WORDSIZE-1:0] REGION_BASE = {16'hFF00, 16'h8000, 16'h0000, 16'h0000},
  parameter logic [NREG*WORDSIZE-1:0] REGION_MASK = {16'hFF00, 16'h8000, 16'h8000, 16'h0000},
  parameter logic [NREG*WAIT_W-1:0]   REGION_WAIT = 16'h0000,
  parameter int                       BOOT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     sys_reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [WORDSIZE-1:0]      cpu_addr,
  input  logic [WORDSIZE-1:0]      cpu_wdata,
  output logic [WORDSIZE-1:0]      cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_err,
  output logic [NREG-1:0]          s_sel,
  output logic                     s_we,
  output logic [WORDSIZE-1:0]      s_addr,
  output logic [WORDSIZE-1:0]      s_wdata,
  input  logic [NREG*WORDSIZE-1:0] s_rdata,
  output logic                     err_flag,
  output logic [WORDSIZE-1:0]      err_addr,
  input  logic                     err_clr,
  output bus_state_t               state_dbg
);

  // Handshake: cpu_req is sampled only in IDLE (and not during sys_reset);
  // the access then completes with a single-cycle cpu_ready pulse, with
  // cpu_err alongside it for unmapped addresses. Holding cpu_req high
  // issues the next access on the edge after the cpu_ready edge.

  localparam int BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

  bus_state_t          state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [IDX_W-1:0]    region_q;
  logic [WORDSIZE-1:0] addr_q;
  logic                we_q;
  logic [BOOT_W-1:0]   boot_cnt;

  logic                dec_hit;
  logic [NREG-1:0]     dec_onehot;
  logic [IDX_W-1:0]    dec_region;
  logic [WAIT_W-1:0]   dec_wait;
  logic [WORDSIZE-1:0] rd_slice;

  reflet_bus_decode #(
    .WORDSIZE    (WORDSIZE),
    .NREG        (NREG),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decode (
    .addr   (cpu_addr),
    .hit    (dec_hit),
    .onehot (dec_onehot),
    .region (dec_region)
  );

  always_comb begin
    dec_wait = '0;
    rd_slice = '0;
    for (int i = 0; i < NREG; i++) begin
      if (dec_region == IDX_W'(i)) dec_wait = REGION_WAIT[i*WAIT_W +: WAIT_W];
      if (region_q == IDX_W'(i))   rd_slice = s_rdata[i*WORDSIZE +: WORDSIZE];
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      region_q  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      s_sel     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      err_flag  <= 1'b0;
      err_addr  <= '0;
      sys_reset <= 1'b1;
      boot_cnt  <= BOOT_W'(BOOT_CYCLES);
    end else begin
      // sys_reset drops on the edge that takes the counter from 1 to 0.
      if (boot_cnt != '0) boot_cnt <= boot_cnt - 1'b1;
      sys_reset <= (boot_cnt > BOOT_W'(1));

      if (err_clr) err_flag <= 1'b0;

      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;

      case (state)
        ST_IDLE: begin
          if (cpu_req && !sys_reset) begin
            addr_q <= cpu_addr;
            we_q   <= cpu_we;
            if (dec_hit) begin
              region_q <= dec_region;
              s_sel    <= dec_onehot;
              s_we     <= cpu_we;
              s_addr   <= cpu_addr;
              s_wdata  <= cpu_wdata;
              wait_cnt <= dec_wait;
              state    <= (dec_wait == '0) ? ST_RESP : ST_WAIT;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == WAIT_W'(1)) state <= ST_RESP;
        end
        ST_RESP: begin
          cpu_ready <= 1'b1;
          cpu_rdata <= we_q ? '0 : rd_slice;
          s_sel     <= '0;
          s_we      <= 1'b0;
          s_addr    <= '0;
          s_wdata   <= '0;
          state     <= ST_IDLE;
        end
        ST_ERR: begin
          cpu_ready <= 1'b1;
          cpu_err   <= 1'b1;
          // Keep the first fault; a capture overrides a coincident err_clr.
          if (!err_flag) begin
            err_flag <= 1'b1;
            err_addr <= addr_q;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_bus_ctrl.sv
// Bench for reflet_bus_ctrl: boot stretch, directed vector table, error
// sequence, back-to-back, reset abort and randomized accesses vs a model.
module tb_reflet_bus_ctrl;
  import reflet_bus_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             sys_reset;
  logic             cpu_req = 1'b0;
  logic             cpu_we = 1'b0;
  logic [W-1:0]     cpu_addr = '0;
  logic [W-1:0]     cpu_wdata = '0;
  logic [W-1:0]     cpu_rdata;
  logic             cpu_ready;
  logic             cpu_err;
  logic [N-1:0]     s_sel;
  logic             s_we;
  logic [W-1:0]     s_addr;
  logic [W-1:0]     s_wdata;
  logic [N*W-1:0]   s_rdata = '0;
  logic             err_flag;
  logic [W-1:0]     err_addr;
  logic             err_clr = 1'b0;
  bus_state_t       state_dbg;

  // Map: r0 FF00-FFFF, r1 8000-FFFF (3 waits), r2 0000-3FFF, r3 6000-7FFF (1 wait).
  reflet_bus_ctrl #(
    .WORDSIZE    (W),
    .NREG        (N),
    .REGION_BASE ({16'h6000, 16'h0000, 16'h8000, 16'hFF00}),
    .REGION_MASK ({16'hE000, 16'hC000, 16'h8000, 16'hFF00}),
    .REGION_WAIT (16'h1030),
    .BOOT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sys_reset (sys_reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .err_flag  (err_flag),
    .err_addr  (err_addr),
    .err_clr   (err_clr),
    .state_dbg (state_dbg)
  );

  // ---- reference model: region table straight from the memory map ----
  logic [W-1:0] m_base [N] = '{16'hFF00, 16'h8000, 16'h0000, 16'h6000};
  logic [W-1:0] m_mask [N] = '{16'hFF00, 16'h8000, 16'hC000, 16'hE000};
  int           m_wait [N] = '{0, 3, 0, 1};

  function automatic int model_region(input logic [W-1:0] a);
    for (int i = 0; i < N; i++)
      if ((a & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  // ---- scoreboard ----
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; lat counts edges from the request edge to the cpu_ready edge.
  task automatic access(input logic [W-1:0] a, input logic we, input logic [W-1:0] wd,
                        output int lat, output logic [N-1:0] sel_or, output int sel_cyc,
                        output logic [W-1:0] rd, output logic err, output logic bus_ok);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    step();
    cpu_req = 1'b0;
    lat = 1; sel_or = '0; sel_cyc = 0; bus_ok = 1'b1;
    while (!cpu_ready && lat < 40) begin
      if (s_sel != '0) begin
        sel_or |= s_sel;
        sel_cyc++;
        if (s_addr !== a || s_we !== we || (we && s_wdata !== wd)) bus_ok = 1'b0;
      end else if (s_we) begin
        bus_ok = 1'b0;
      end
      if (cpu_rdata != '0 || cpu_err) bus_ok = 1'b0;
      step();
      lat++;
    end
    rd  = cpu_rdata;
    err = cpu_err;
  endtask

  task automatic wait_boot(output int cnt);
    int guard;
    cnt = sys_reset ? 1 : 0;
    guard = 0;
    while (sys_reset && guard < 40) begin
      step();
      guard++;
      if (sys_reset) cnt++;
    end
  endtask

  typedef struct {
    logic [W-1:0] addr;
    logic         we;
    logic [W-1:0] wdata;
    logic [N-1:0] exp_sel;
    logic         exp_err;
    int           exp_lat;
    logic [W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, sel_cyc, cnt, rdy_cnt;
    logic [N-1:0] sel_or;
    logic [W-1:0] rd;
    logic err, bus_ok, seen, dbl, prev;
    logic mflag;
    logic [W-1:0] maddr;

    vecs[0] = '{16'h0010, 1'b0, 16'h0000, 4'b0100, 1'b0, 2, 16'h1234};
    vecs[1] = '{16'h8002, 1'b1, 16'hBEEF, 4'b0010, 1'b0, 5, 16'h0000};
    vecs[2] = '{16'hFF05, 1'b0, 16'h0000, 4'b0001, 1'b0, 2, 16'hA0A0};
    vecs[3] = '{16'h6004, 1'b0, 16'h0000, 4'b1000, 1'b0, 3, 16'hD3D3};
    vecs[4] = '{16'h9000, 1'b0, 16'h0000, 4'b0010, 1'b0, 5, 16'hB1B1};
    vecs[5] = '{16'h3FFF, 1'b1, 16'h5A5A, 4'b0100, 1'b0, 2, 16'h0000};
    vecs[6] = '{16'h5000, 1'b0, 16'h0000, 4'b0000, 1'b1, 2, 16'h0000};

    // Reset values
    repeat (3) step();
    check("rst_sys_reset", 32'(sys_reset), 32'd1);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_sel", 32'(s_sel), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // Boot stretch with a request pending that must be ignored
    cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_we = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    cnt = 1;
    for (int g = 0; g < 40 && sys_reset; g++) begin
      step();
      if (sys_reset) cnt++;
      if (cpu_ready || s_sel != '0) seen = 1'b1;
    end
    cpu_req = 1'b0;
    check("boot_len", 32'(cnt), 32'd16);
    check("boot_req_ignored", 32'(seen), 32'd0);
    check("boot_state", 32'(state_dbg), 32'(ST_IDLE));

    // Directed vector table
    s_rdata = {16'hD3D3, 16'h1234, 16'hB1B1, 16'hA0A0};
    for (int i = 0; i < 7; i++) begin
      access(vecs[i].addr, vecs[i].we, vecs[i].wdata, lat, sel_or, sel_cyc, rd, err, bus_ok);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_sel", i), 32'(sel_or), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_sel_cycles", i), 32'(sel_cyc), vecs[i].exp_err ? 32'd0 : 32'(vecs[i].exp_lat - 1));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_bus", i), 32'(bus_ok), 32'd1);
    end
    check("vec_err_addr", 32'(err_addr), 32'h5000);

    // Error sequence: first fault retained, err_clr clears, capture beats clear
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("clr0_flag", 32'(err_flag), 32'd0);
    access(16'h4000, 1'b0, 16'h0, lat, sel_or, sel_cyc, rd, err, bus_ok);
    check("err1_pulse", 32'(err), 32'd1);
    check("err1_sel", 32'(sel_or), 32'd0);
    access(16'h4001, 1'b1, 16'hFFFF, lat, sel_or, sel_cyc, rd, err, bus_ok);
    check("err2_pulse", 32'(err), 32'd1);
    check("err2_bus", 32'(bus_ok), 32'd1);
    step();
    check("err_flag_set", 32'(err_flag), 32'd1);
    check("err_addr_first", 32'(err_addr), 32'h4000);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_clr_flag", 32'(err_flag), 32'd0);
    err_clr = 1'b1;
    access(16'h4002, 1'b0, 16'h0, lat, sel_or, sel_cyc, rd, err, bus_ok);
    err_clr = 1'b0;
    check("clr_vs_capture_flag", 32'(err_flag), 32'd1);
    check("clr_vs_capture_addr", 32'(err_addr), 32'h4002);

    // Back-to-back reads with cpu_req held high
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    rdy_cnt = 0; dbl = 1'b0; prev = 1'b0; bus_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (cpu_ready) begin
        rdy_cnt++;
        if (cpu_rdata !== 16'h1234) bus_ok = 1'b0;
      end else if (cpu_rdata != '0) begin
        bus_ok = 1'b0;
      end
      if (cpu_ready && prev) dbl = 1'b1;
      prev = cpu_ready;
    end
    cpu_req = 1'b0;
    step();
    check("b2b_count", 32'(rdy_cnt), 32'd4);
    check("b2b_single_pulse", 32'(dbl), 32'd0);
    check("b2b_rdata", 32'(bus_ok), 32'd1);

    // Randomized accesses against the model
    err_clr = 1'b1; step(); err_clr = 1'b0;
    mflag = 1'b0; maddr = '0;
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] a, wd, exp_rd;
      logic we;
      int r;
      s_rdata = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        err_clr = 1'b1; step(); err_clr = 1'b0;
        mflag = 1'b0;
      end
      a  = W'($urandom);
      we = 1'($urandom_range(0, 1));
      wd = W'($urandom);
      r  = model_region(a);
      exp_rd = (r < 0 || we) ? '0 : s_rdata[r*W +: W];
      if (r < 0 && !mflag) begin
        mflag = 1'b1;
        maddr = a;
      end
      access(a, we, wd, lat, sel_or, sel_cyc, rd, err, bus_ok);
      check($sformatf("rnd%0d_lat a=%h", t, a), 32'(lat), (r < 0) ? 32'd2 : 32'(2 + m_wait[r]));
      check($sformatf("rnd%0d_err", t), 32'(err), (r < 0) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_sel", t), 32'(sel_or), (r < 0) ? 32'd0 : (32'd1 << r));
      check($sformatf("rnd%0d_rdata", t), 32'(rd), 32'(exp_rd));
      check($sformatf("rnd%0d_bus", t), 32'(bus_ok), 32'd1);
      step();
      check($sformatf("rnd%0d_err_flag", t), 32'(err_flag), 32'(mflag));
      if (mflag) check($sformatf("rnd%0d_err_addr", t), 32'(err_addr), 32'(maddr));
    end

    // Reset in the middle of a wait-state access aborts it
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8002; cpu_wdata = 16'hBEEF;
    step();
    cpu_req = 1'b0;
    step();
    check("abort_in_wait", 32'(state_dbg), 32'(ST_WAIT));
    check("abort_sel_before", 32'(s_sel), 32'b0010);
    reset = 1'b1;
    step();
    check("abort_ready", 32'(cpu_ready), 32'd0);
    check("abort_sel", 32'(s_sel), 32'd0);
    check("abort_we", 32'(s_we), 32'd0);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_sys_reset", 32'(sys_reset), 32'd1);
    seen = 1'b0;
    repeat (3) begin
      step();
      if (cpu_ready) seen = 1'b1;
    end
    reset = 1'b0;
    wait_boot(cnt);
    check("abort_no_ready", 32'(seen), 32'd0);
    check("reboot_len", 32'(cnt), 32'd16);
    check("reboot_err_flag", 32'(err_flag), 32'd0);
    s_rdata = {16'hD3D3, 16'h1234, 16'hB1B1, 16'hA0A0};
    access(16'h0010, 1'b0, 16'h0, lat, sel_or, sel_cyc, rd, err, bus_ok);
    check("reboot_lat", 32'(lat), 32'd2);
    check("reboot_rdata", 32'(rd), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
